mem_rr_arbiter: RTL
===================

# mem_rr_arbiter

Round-robin arbiter and sequencer that shares the single SDRAM command port among up to 16 memory masters (delay lines, chorus, future effects). Each master sees a private window of `ADDR_WIDTH` words; the arbiter prefixes the master index to form the physical address, issues one command at a time, and returns acknowledgements and read data to the owning master. It sits between the application core and the SDRAM controller.

## Interface
- `NUM_MASTERS`, 16: number of requesters; power of two, 2..16.
- `ADDR_WIDTH`, 16: per-master word address width (`20 - $clog2(NUM_MASTERS)`).
- `DATA_WIDTH`, 16: memory word width.
- `TIMEOUT`, 255: watchdog limit in cycles (used only with `MEM_ARB_WATCHDOG_EN`).
- `clk_i` in 1: system clock; the block uses one clock.
- `srst_i` in 1: synchronous, active-high reset.
- `req_i` in `NUM_MASTERS`: request per master, held until its `ack_o`.
- `we_i` in `NUM_MASTERS`: 1 = write, 0 = read; stable while `req_i` is high.
- `addr_i` in `NUM_MASTERS*ADDR_WIDTH`: packed local addresses, master 0 at the LSBs.
- `wdata_i` in `NUM_MASTERS*DATA_WIDTH`: packed write data.
- `ack_o` out `NUM_MASTERS`: one-cycle completion pulse.
- `rvalid_o` out `NUM_MASTERS`: one-cycle read-data pulse, coincident with `ack_o` for reads.
- `rdata_o` out `DATA_WIDTH`: read data, shared, valid only while some `rvalid_o` bit is high.
- `err_o` out `NUM_MASTERS`: timeout pulse, coincident with `ack_o`.
- `mem_req_o` out 1: command valid to the SDRAM controller.
- `mem_we_o` out 1: command direction.
- `mem_addr_o` out `ADDR_WIDTH+$clog2(NUM_MASTERS)`: {grant index, local address}.
- `mem_wdata_o` out `DATA_WIDTH`: write data.
- `mem_ready_i` in 1: controller accepts the command this cycle.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in `DATA_WIDTH`: read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE: compute the eligible set as `req_i & ~ack_o`, so a master acknowledged in this cycle is excluded. If the set is non-empty, select the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_MASTERS`. Register the grant index and its command fields (`we`, `{idx, addr}`, `wdata`), update `last_grant`, and go to ISSUE.
- ISSUE: `mem_req_o`=1 with the registered command held stable.
  - On `mem_req_o & mem_ready_i` with a write: pulse `ack_o[g]` next cycle and go to IDLE.
  - On the same handshake with a read: go to WAIT_RD.
- WAIT_RD: `mem_req_o`=0. On `mem_rvalid_i`, register `mem_rdata_i` into `rdata_o`, pulse `rvalid_o[g]` and `ack_o[g]` next cycle, and go to IDLE.
- Exactly one command is outstanding at any time. `mem_rvalid_i` is ignored outside WAIT_RD.
- Changes to `req_i` or `we_i` for the granted master after grant are ignored until completion. The latched command is issued regardless.
- `srst_i` mid-operation:
  - FSM returns to IDLE and `last_grant` is set to `NUM_MASTERS-1`, so master 0 has priority first.
  - All outputs clear.
  - A later `mem_rvalid_i` belonging to the aborted read is dropped.

## Timing
- Reset values: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `ack_o`, `rvalid_o`, `err_o`, `rdata_o` are all 0.
- Request at cycle 0 in IDLE: `mem_req_o` is high at cycle 1.
- Write accepted at cycle n: `ack_o` is high at cycle n+1, and the FSM is in IDLE at n+1. The next grant's `mem_req_o` is high at n+2.
- Read data arriving at cycle m: `rvalid_o`, `ack_o` and `rdata_o` are valid at cycle m+1.
- Minimum spacing between back-to-back writes is 2 cycles when `mem_ready_i` is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_WATCHDOG_EN` defined:
  - A counter clears on entry to ISSUE and counts in ISSUE and WAIT_RD.
  - When it reaches `TIMEOUT`, pulse `ack_o[g]` and `err_o[g]` next cycle, with `rvalid_o` and `rdata_o` at 0, and go to IDLE.
  - A handshake or data arriving in the same cycle as the timeout takes priority over the timeout.
- Without the macro: no counter, `err_o` is tied to 0, and the arbiter waits indefinitely.

## Structure
- Shared package holds the FSM state enum `mem_arb_state_t` and the packed command struct `mem_arb_cmd_t` (we, addr, wdata).
- `NUM_MASTERS` and `ADDR_WIDTH` come from `main_config` (`NUM_MEMORY_MASTERS`, `MEM_ADDR_WIDTH`).
- One sub-module: `rr_priority_picker` (combinational rotate, priority-encode, un-rotate), which returns the index and a found flag.

## Test plan
- Reset, then master 3 writes 0x1234 to local address 0x0042 with `mem_ready_i`=1: `mem_addr_o`=0x30042 at cycle 1 and `ack_o[3]` at cycle 2.
- Masters 0, 5 and 15 request continuously: grants occur in order 0, 5, 15, 0, … and no master gets two consecutive grants while others wait.
- Master 7 reads, `mem_ready_i` is delayed 4 cycles, and `mem_rvalid_i` arrives 6 cycles later with 0xBEEF: exactly one `rvalid_o[7]`/`ack_o[7]` pulse, with `rdata_o`=0xBEEF.
- `srst_i` is asserted in WAIT_RD, then a stray `mem_rvalid_i` arrives: no `rvalid_o` pulse, and the next grant goes to master 0.
- With `MEM_ARB_WATCHDOG_EN` and `TIMEOUT`=8, master 2 reads with no `mem_rvalid_i`: `ack_o[2]` and `err_o[2]` pulse, then other masters proceed.
- Master 1 drops `req_i` on its ack cycle while master 1 and master 4 request: master 4 is granted next, with no duplicate grant to master 1.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types for the SDRAM round-robin arbiter: FSM states, the latched command, default sizing.
// Default sizing mirrors main_config (NUM_MEMORY_MASTERS, MEM_ADDR_WIDTH); physical address is fixed at 20 bits.
package mem_rr_arbiter_pkg;

    localparam int NUM_MEMORY_MASTERS  = 16;
    localparam int MEM_ADDR_WIDTH      = 16;
    localparam int MEM_PHYS_ADDR_WIDTH = 20;
    localparam int MEM_DATA_WIDTH      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } mem_arb_state_t;

    typedef struct packed {
        logic                           we;
        logic [MEM_PHYS_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0]      wdata;
    } mem_arb_cmd_t;

endpackage

// File: rtl/mem_rr_arbiter_picker.sv
// Purpose: round-robin pick of the first set request searching upward from last+1, wrapping.
// Latency: purely combinational. Backpressure: none; the caller decides when to consume the pick.
module rr_priority_picker #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] start;
    logic [IW-1:0] offset;
    logic [N-1:0]  rot;

    // N is a power of two, so IW-bit additions wrap modulo N for free.
    always_comb begin
        start  = last + IW'(1);
        rot    = '0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[start + IW'(i)];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IW'(i);
            end
        end
        found = |rot;
        idx   = start + offset;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Purpose: round-robin sharing of one SDRAM command port, one command outstanding; MEM_ARB_WATCHDOG_EN adds a timeout.
// Latency: request->mem_req 1 cycle, accept/read data->ack 1 cycle. Backpressure: holds command until mem_ready_i.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MEMORY_MASTERS,
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                                      clk_i,
    input  logic                                      srst_i,
    input  logic [NUM_MASTERS-1:0]                    req_i,
    input  logic [NUM_MASTERS-1:0]                    we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]         addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]         wdata_i,
    output logic [NUM_MASTERS-1:0]                    ack_o,
    output logic [NUM_MASTERS-1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]                     rdata_o,
    output logic [NUM_MASTERS-1:0]                    err_o,
    output logic                                      mem_req_o,
    output logic                                      mem_we_o,
    output logic [ADDR_WIDTH+$clog2(NUM_MASTERS)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]                     mem_wdata_o,
    input  logic                                      mem_ready_i,
    input  logic                                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata_i
);

    localparam int IW  = $clog2(NUM_MASTERS);
    localparam int PAW = ADDR_WIDTH + IW;

    mem_arb_state_t         state_q, state_d;
    mem_arb_cmd_t           cmd_q;
    logic [IW-1:0]          gnt_q, last_q, pick_idx;
    logic                   pick_found, load;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] ack_q, ack_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   mem_req_q;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_arr[i]  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A master whose ack is visible this cycle may still hold req_i; keep it out.
    assign eligible = req_i & ~ack_q;

    rr_priority_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
        .req   (eligible),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]          wd_cnt_q;
    logic                   wd_hit;
    logic [NUM_MASTERS-1:0] err_q, err_d;

    assign wd_hit = (state_q != IDLE) && (wd_cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (srst_i || load) begin
            wd_cnt_q <= '0;
        end else if (state_q != IDLE && wd_cnt_q != CW'(TIMEOUT)) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        ack_d    = '0;
        rvalid_d = '0;
        rdata_d  = '0;
`ifdef MEM_ARB_WATCHDOG_EN
        err_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            // mem_req_o is high throughout ISSUE, so mem_ready_i alone completes the handshake.
            ISSUE: begin
                if (mem_ready_i) begin
                    if (cmd_q.we) begin
                        ack_d[gnt_q] = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
`ifdef MEM_ARB_WATCHDOG_EN
                else if (wd_hit) begin
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                    state_d      = IDLE;
                end
`endif
            end
            WAIT_RD: begin
                if (mem_rvalid_i) begin
                    ack_d[gnt_q]    = 1'b1;
                    rvalid_d[gnt_q] = 1'b1;
                    rdata_d         = mem_rdata_i;
                    state_d         = IDLE;
                end
`ifdef MEM_ARB_WATCHDOG_EN
                else if (wd_hit) begin
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                    state_d      = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            last_q    <= IW'(NUM_MASTERS - 1);
            gnt_q     <= '0;
            cmd_q     <= '0;
            ack_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            mem_req_q <= (state_d == ISSUE);
            if (load) begin
                gnt_q       <= pick_idx;
                last_q      <= pick_idx;
                cmd_q.we    <= we_i[pick_idx];
                cmd_q.addr  <= MEM_PHYS_ADDR_WIDTH'({pick_idx, addr_arr[pick_idx]});
                cmd_q.wdata <= MEM_DATA_WIDTH'(wdata_arr[pick_idx]);
            end
        end
    end

    assign ack_o       = ack_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = cmd_q.we;
    assign mem_addr_o  = cmd_q.addr[PAW-1:0];
    assign mem_wdata_o = cmd_q.wdata[DATA_WIDTH-1:0];

endmodule
